card_info_lookup: RTL and testbench

//  Multi-field card-attribute lookup that follows the BIN binary search. A matched
//  BIN index selects a packed row of per-field name pointers from an index ROM.

---
 rtl/card_info_lookup.sv | 144 ++++++++++++++
 tb/tb_card_info_lookup.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/card_info_lookup.sv
// rtl/card_info_lookup.sv - Multi-field card attribute lookup: BIN index -> pointer row -> field names.
module card_info_lookup #(
    parameter int INDEX_DEPTH = 2638,
    parameter int INDEX_AW    = 12,
    parameter int NUM_FIELDS  = 2,
    parameter int PTR_W       = 4,
    parameter int NAME_DEPTH  = 16,
    parameter int NAME_W      = 80,
    parameter logic [NAME_W-1:0] NOT_FOUND = 80'h4E4F5420464F554E4420
) (
    input  logic                         CLOCK_50,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         req_found,
    input  logic [INDEX_AW-1:0]          req_index,
    output logic                         busy,
    output logic                         done,
    output logic                         hit,
    output logic                         out_of_range,
    output logic [NUM_FIELDS*NAME_W-1:0] fields
);

    localparam int ROW_W = NUM_FIELDS * PTR_W;
    localparam int FW    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IDX,
        S_NAME,
        S_CAPT,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [FW-1:0]                  f_q, f_d;
    logic [INDEX_AW-1:0]            idx_q, idx_d;
    logic [NUM_FIELDS*NAME_W-1:0]   fields_q, fields_d;
    logic                           hit_q, hit_d;
    logic                           oor_q, oor_d;
    logic [ROW_W-1:0]               row_q;
    logic [NAME_W-1:0]              name_q;
    logic                           ptr_bad_q;
    logic [PTR_W-1:0]               cur_ptr;

    // ROM contents: field f of row r points at name (3*r + 2*f + 1) mod 2**PTR_W.
    function automatic logic [ROW_W-1:0] idx_rom_word(input logic [INDEX_AW-1:0] a);
        logic [ROW_W-1:0] w;
        int v;
        w = '0;
        v = int'(a);
        for (int f = 0; f < NUM_FIELDS; f++) begin
            w[f*PTR_W +: PTR_W] = PTR_W'(3 * v + 2 * f + 1);
        end
        return w;
    endfunction

    // Name p is the ten characters "FIELD_<two decimal digits>  ".
    function automatic logic [NAME_W-1:0] name_rom_word(input logic [PTR_W-1:0] p);
        int v;
        v = int'(p);
        return NAME_W'({"FIELD_", 8'(8'h30 + v / 10), 8'(8'h30 + v % 10), "  "});
    endfunction

    assign cur_ptr = row_q[int'(f_q)*PTR_W +: PTR_W];

    always_ff @(posedge CLOCK_50) begin
        row_q     <= idx_rom_word(idx_q);
        name_q    <= name_rom_word(cur_ptr);
        ptr_bad_q <= (int'(cur_ptr) >= NAME_DEPTH);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            f_q      <= '0;
            idx_q    <= '0;
            fields_q <= '0;
            hit_q    <= 1'b0;
            oor_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            f_q      <= f_d;
            idx_q    <= idx_d;
            fields_q <= fields_d;
            hit_q    <= hit_d;
            oor_q    <= oor_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        f_d      = f_q;
        idx_d    = idx_q;
        fields_d = fields_q;
        hit_d    = hit_q;
        oor_d    = oor_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_d    = req_index;
                    fields_d = '0;
                    hit_d    = 1'b0;
                    oor_d    = 1'b0;
                    if (!req_found) begin
                        state_d  = S_DONE;
                        fields_d = {NUM_FIELDS{NOT_FOUND}};
                    end else if (int'(req_index) >= INDEX_DEPTH) begin
                        state_d  = S_DONE;
                        oor_d    = 1'b1;
                        fields_d = {NUM_FIELDS{NOT_FOUND}};
                    end else begin
                        state_d = S_IDX;
                    end
                end
            end
            S_IDX: begin
                state_d = S_NAME;
                f_d     = '0;
            end
            S_NAME: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                fields_d[int'(f_q)*NAME_W +: NAME_W] = ptr_bad_q ? NOT_FOUND : name_q;
                if (f_q == FW'(NUM_FIELDS - 1)) begin
                    state_d = S_DONE;
                    hit_d   = 1'b1;
                end else begin
                    f_d     = f_q + 1'b1;
                    state_d = S_NAME;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q == S_IDX) || (state_q == S_NAME) || (state_q == S_CAPT);
    assign done         = (state_q == S_DONE);
    assign hit          = hit_q;
    assign out_of_range = oor_q;
    // Partially captured fields stay internal until the result is complete.
    assign fields       = done ? fields_q : '0;

endmodule

// File: tb/tb_card_info_lookup.sv
// tb/tb_card_info_lookup.sv - Randomized self-checking bench for card_info_lookup.
module tb_card_info_lookup;

    localparam int DEPTH = 2638;
    localparam int NF    = 2;
    localparam logic [79:0] NF_STR = "NOT FOUND ";

    logic          CLOCK_50 = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          req_found = 1'b0;
    logic [11:0]   req_index = '0;
    logic          busy, done, hit, out_of_range;
    logic [159:0]  fields;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    card_info_lookup dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .start       (start),
        .req_found   (req_found),
        .req_index   (req_index),
        .busy        (busy),
        .done        (done),
        .hit         (hit),
        .out_of_range(out_of_range),
        .fields      (fields)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [79:0] name_of(input int p);
        return {"FIELD_", 8'(8'h30 + p / 10), 8'(8'h30 + p % 10), "  "};
    endfunction

    function automatic logic [159:0] lookup(input int r);
        logic [159:0] v;
        for (int f = 0; f < NF; f++) v[f*80 +: 80] = name_of((3 * r + 2 * f + 1) % 16);
        return v;
    endfunction

    // Reference: a hit request occupies the block for 1+2*NF cycles, then reports.
    int           busy_left = 0;
    logic         m_done = 0, m_hit = 0, m_oor = 0;
    logic [159:0] m_fields = '0, pend_fields = '0;

    always @(posedge CLOCK_50) begin
        if (!resetn) begin
            busy_left = 0; m_done = 0; m_hit = 0; m_oor = 0; m_fields = '0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                m_done = 1; m_hit = 1; m_fields = pend_fields;
            end
        end else if (start) begin
            m_done = 0; m_hit = 0; m_oor = 0; m_fields = '0;
            if (!req_found) begin
                m_done = 1; m_fields = {NF{NF_STR}};
            end else if (int'(req_index) >= DEPTH) begin
                m_done = 1; m_oor = 1; m_fields = {NF{NF_STR}};
            end else begin
                busy_left   = 1 + 2 * NF;
                pend_fields = lookup(int'(req_index));
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            n_cmp++;
            if (busy !== (busy_left > 0) || done !== m_done || hit !== m_hit ||
                out_of_range !== m_oor || fields !== m_fields) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t got busy=%b done=%b hit=%b oor=%b fields=%h want busy=%b done=%b hit=%b oor=%b fields=%h",
                         $time, busy, done, hit, out_of_range, fields,
                         (busy_left > 0), m_done, m_hit, m_oor, m_fields);
            end
        end
    end

    task automatic check(input string nm, input logic [159:0] got, input logic [159:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic req(input logic f, input int idx);
        start = 1'b1; req_found = f; req_index = 12'(idx);
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 50) begin
            @(negedge CLOCK_50);
            edges++;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_done timeout got=0 want=1");
        end
    endtask

    int e;

    initial begin
        repeat (2) @(negedge CLOCK_50);
        chk_en = 1'b1;
        check("reset_outputs", {busy, done, hit, out_of_range, fields}, '0);
        resetn = 1'b1;
        @(negedge CLOCK_50);

        req(1'b1, 0);
        check("t1_busy_edge1", busy, 1);
        wait_done(e);
        check("t1_latency", e, 5);
        check("t1_fields", fields, {"FIELD_03  ", "FIELD_01  "});
        check("t1_hit", hit, 1);

        req(1'b0, 5);
        check("t2_done", done, 1);
        check("t2_fields", fields, {"NOT FOUND ", "NOT FOUND "});
        check("t2_hit_oor", {hit, out_of_range}, 2'b00);

        req(1'b1, 2638);
        check("t3_hit_oor", {done, hit, out_of_range}, 3'b101);
        check("t3_fields", fields, {NF_STR, NF_STR});

        req(1'b1, 7);
        @(negedge CLOCK_50);
        req(1'b1, 100);
        wait_done(e);
        check("t4_latency", e, 3);
        check("t4_fields", fields, lookup(7));

        req(1'b1, 9);
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b0;
        @(negedge CLOCK_50);
        resetn = 1'b1;
        check("t5_after_reset", {busy, done, hit, out_of_range, fields}, '0);
        req(1'b1, 9);
        wait_done(e);
        check("t5_fields", fields, lookup(9));

        req(1'b1, DEPTH - 1);
        wait_done(e);
        check("t6_gap", e, 5);
        check("t6_fields", fields, {"FIELD_10  ", "FIELD_08  "});
        req(1'b0, 0);
        check("t6_b2b_miss_done", done, 1);

        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
            if ($urandom_range(0, 24) == 0) begin
                resetn = 1'b0;
                @(negedge CLOCK_50);
                resetn = 1'b1;
            end
            start     = 1'b1;
            req_found = ($urandom_range(0, 4) != 0);
            req_index = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(2630, 4095))
                                                    : 12'($urandom_range(0, DEPTH - 1));
            repeat ($urandom_range(1, 3)) @(negedge CLOCK_50);
            start = 1'b0;
        end
        repeat (10) @(negedge CLOCK_50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
